seq_alu: RTL and testbench

Parametrised, multi-cycle signed ALU with a start/done handshake. It succeeds the 6-bit combinational `alu_top` and sits between the operand registers and the result bus. Add and subtract are single-cycle. Multiply and divide are iterative, one bit per clock. Division is fully signed and flags divide-by-zero, which the previous generation did not support.

---
 rtl/seq_alu_pkg.sv | 21 ++
 rtl/seq_alu_if.sv | 32 +++
 rtl/seq_muldiv.sv | 85 ++++++++
 rtl/seq_alu.sv | 167 ++++++++++++++++
 tb/tb_seq_alu.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Function codes and FSM state encoding shared by the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Purpose  : Request/result bundle between the operand side and seq_alu.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 6
) ();

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [1:0]             func;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     out;
    logic                   overflow;
    logic                   div_by_zero;

    modport master (
        output start, a, b, func,
        input  busy, done, out, overflow, div_by_zero
    );

    modport slave (
        input  start, a, b, func,
        output busy, done, out, overflow, div_by_zero
    );

endinterface
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : seq_muldiv
// Purpose  : Unsigned one-bit-per-clock shift-add multiplier / restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module seq_muldiv #(
    parameter int WIDTH = 6
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_load,
    input  wire logic                   i_step,
    input  wire logic                   i_div,
    input  wire logic [WIDTH-1:0]       i_mag_a,
    input  wire logic [WIDTH-1:0]       i_mag_b,
    output logic                        o_last,
    output logic [2*WIDTH-1:0]          o_next_result
);

    localparam int                CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

    // r_acc: partial product high half / partial remainder.
    // r_lo : multiplier being shifted out / dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_m;
    logic               r_div;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_addend;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_acc_n;
    logic [WIDTH-1:0]   w_lo_n;

    assign w_mul_addend = r_lo[0] ? r_m : '0;
    assign w_mul_sum    = {1'b0, r_acc} + {1'b0, w_mul_addend};

    assign w_shift      = {r_acc, r_lo[WIDTH-1]};
    assign w_trial      = {1'b0, w_shift} - {2'b00, r_m};
    assign w_fits       = ~w_trial[WIDTH+1];

    always_comb begin
        w_acc_n = '0;
        w_lo_n  = '0;
        if (r_div) begin
            // A partial remainder is always below the divisor, so W bits suffice.
            w_acc_n = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_lo_n  = {r_lo[WIDTH-2:0], w_fits};
        end else begin
            w_acc_n = w_mul_sum[WIDTH:1];
            w_lo_n  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_last        = (r_cnt == c_last_cnt);
    assign o_next_result = r_div ? {w_lo_n, w_acc_n} : {w_acc_n, w_lo_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_lo  <= i_div ? i_mag_a : i_mag_b;
            r_m   <= i_div ? i_mag_b : i_mag_a;
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle signed ALU (add/sub/mul/div) with start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_alu_if.slave    bus
);

    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [1:0]             r_func;
    logic                   r_first;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_out;
    logic                   r_ovf;
    logic                   r_dbz;

    logic                   w_accept;
    logic                   w_b_zero;
    logic                   w_fast;
    logic                   w_load;
    logic                   w_step;
    logic                   w_last;
    logic                   w_fin;
    logic                   w_neg_res;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH-1:0]       w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic [2*WIDTH-1:0]     w_md_res;
    logic [WIDTH-1:0]       w_quot;
    logic [WIDTH-1:0]       w_rem;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_res_out;
    logic                   w_res_ovf;
    logic                   w_res_dbz;

    // FIN is not busy, so a back-to-back request is taken there with no bubble.
    assign w_accept  = bus.start && (r_state != RUN);
    assign w_b_zero  = (r_b == '0);
    assign w_fast    = (r_func == FUNC_ADD) || (r_func == FUNC_SUB) ||
                       ((r_func == FUNC_DIV) && w_b_zero);
    assign w_load    = (r_state == RUN) && r_first && !w_fast;
    assign w_step    = (r_state == RUN) && !r_first;
    assign w_fin     = (r_state == RUN) && (r_first ? w_fast : w_last);

    // Unsigned W-bit magnitudes keep |-2^(W-1)| representable.
    assign w_mag_a   = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_mag_b   = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_neg_res = r_a[WIDTH-1] ^ r_b[WIDTH-1];

    assign w_sum     = r_a + r_b;
    assign w_diff    = r_a - r_b;

    assign w_quot    = w_neg_res    ? -w_md_res[2*WIDTH-1:WIDTH] : w_md_res[2*WIDTH-1:WIDTH];
    assign w_rem     = r_a[WIDTH-1] ? -w_md_res[WIDTH-1:0]       : w_md_res[WIDTH-1:0];
    assign w_prod    = w_neg_res    ? -w_md_res                  : w_md_res;

    seq_muldiv #(
        .WIDTH          (WIDTH)
    ) u_muldiv (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_load),
        .i_step         (w_step),
        .i_div          (r_func == FUNC_DIV),
        .i_mag_a        (w_mag_a),
        .i_mag_b        (w_mag_b),
        .o_last         (w_last),
        .o_next_result  (w_md_res)
    );

    always_comb begin
        w_res_out = '0;
        w_res_ovf = 1'b0;
        w_res_dbz = 1'b0;
        case (r_func)
            FUNC_ADD: begin
                w_res_out = {{WIDTH{w_sum[WIDTH-1]}}, w_sum};
                w_res_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            FUNC_SUB: begin
                w_res_out = {{WIDTH{w_diff[WIDTH-1]}}, w_diff};
                w_res_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            FUNC_MUL: begin
                w_res_out = w_prod;
            end
            default: begin
                if (w_b_zero) begin
                    w_res_out = {{WIDTH{1'b1}}, r_a};
                    w_res_dbz = 1'b1;
                end else begin
                    // MIN/-1 naturally wraps to MIN with remainder 0; only the flag is special.
                    w_res_out = {w_quot, w_rem};
                    w_res_ovf = (r_a == c_min_neg) && (r_b == '1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_func  <= FUNC_ADD;
            r_first <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_func  <= bus.func;
                        r_first <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_first <= 1'b0;
                    if (w_fin) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= w_res_out;
                        r_ovf   <= w_res_ovf;
                        r_dbz   <= w_res_dbz;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.out         = r_out;
    assign bus.overflow    = r_ovf;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Directed and swept checks of seq_alu against an integer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 6;

    typedef struct {
        logic [2*W-1:0] out;
        logic           ovf;
        logic           dbz;
        int             lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t model(input int a, input int b, input logic [1:0] f);
        exp_t e;
        int r, q, m;
        logic [31:0] v, qv, mv;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        e.lat = 1;
        e.out = '0;
        case (f)
            FUNC_ADD, FUNC_SUB: begin
                r = (f == FUNC_ADD) ? a + b : a - b;
                e.ovf = (r > 31) || (r < -32);
                if (r > 31)  r = r - 64;
                if (r < -32) r = r + 64;
                v = r;
                e.out = v[2*W-1:0];
            end
            FUNC_MUL: begin
                v = a * b;
                e.out = v[2*W-1:0];
                e.lat = W + 1;
            end
            default: begin
                if (b == 0) begin
                    v = a;
                    e.out = {6'h3F, v[5:0]};
                    e.dbz = 1'b1;
                end else begin
                    if (a == -32 && b == -1) begin
                        q = -32; m = 0; e.ovf = 1'b1;
                    end else begin
                        q = a / b; m = a % b;
                    end
                    qv = q; mv = m;
                    e.out = {qv[5:0], mv[5:0]};
                    e.lat = W + 1;
                end
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a, input int b, input logic [1:0] f);
        sb.push_back(model(a, b, f));
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.func  = f;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    // Waits for done; lat0 cycles of the operation have already elapsed in RUN.
    task automatic wait_check(input int lat0, input string tag);
        exp_t e;
        int   lat    = lat0;
        int   busy_n = lat0;
        bit   seen   = 1'b0;
        while (!seen && lat < 30) begin
            if (bus.busy) busy_n++;
            cyc();
            lat++;
            seen = bus.done;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " latency"},  lat,             e.lat);
            chk({tag, " busy_cyc"}, busy_n,          e.lat);
            chk({tag, " busy_fin"}, 32'(bus.busy),   32'd0);
            chk({tag, " out"},      32'(bus.out),    32'(e.out));
            chk({tag, " overflow"}, 32'(bus.overflow),    32'(e.ovf));
            chk({tag, " div0"},     32'(bus.div_by_zero), 32'(e.dbz));
        end
    endtask

    task automatic run_op(input int a, input int b, input logic [1:0] f, input string tag);
        issue(a, b, f);
        wait_check(0, tag);
    endtask

    function automatic bit sel_b(input int b);
        return (b % 4 == 0) || (b >= -2 && b <= 2) || (b == 31) || (b == -31);
    endfunction

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.func  = FUNC_ADD;
        cyc(); cyc();
        chk("reset busy",  32'(bus.busy),        32'd0);
        chk("reset done",  32'(bus.done),        32'd0);
        chk("reset out",   32'(bus.out),         32'd0);
        chk("reset ovf",   32'(bus.overflow),    32'd0);
        chk("reset div0",  32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        cyc();

        run_op(31, 1, FUNC_ADD, "add 31+1");
        chk("add 31+1 lit", 32'(bus.out[5:0]), 32'h20);
        run_op(5, 7, FUNC_SUB, "sub 5-7");
        chk("sub 5-7 lit", 32'(bus.out), 32'hFFE);
        run_op(-32, 1, FUNC_SUB, "sub -32-1");
        chk("sub -32-1 lit", 32'(bus.out[5:0]), 32'd31);
        run_op(-32, -32, FUNC_MUL, "mul -32*-32");
        chk("mul -32*-32 lit", 32'(bus.out), 32'h400);
        run_op(31, -32, FUNC_MUL, "mul 31*-32");
        chk("mul 31*-32 lit", 32'(bus.out), 32'hC20);
        run_op(-17, 5, FUNC_DIV, "div -17/5");
        run_op(-32, -1, FUNC_DIV, "div -32/-1");
        run_op(7, 0, FUNC_DIV, "div 7/0");
        chk("div 7/0 lit", 32'(bus.out), 32'hFC7);

        // Reset part-way through a divide: outputs clear at once, no done follows.
        bus.a = 6'd20; bus.b = 6'd3; bus.func = FUNC_DIV; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc(); cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(bus.busy),        32'd0);
        chk("abort done", 32'(bus.done),        32'd0);
        chk("abort out",  32'(bus.out),         32'd0);
        chk("abort ovf",  32'(bus.overflow),    32'd0);
        chk("abort div0", 32'(bus.div_by_zero), 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("abort no done", 32'(bus.done), 32'd0);
        end
        run_op(-5, 3, FUNC_ADD, "add after abort");

        // Start while busy is dropped; operands change but the mul result must not.
        issue(3, 5, FUNC_MUL);
        cyc(); cyc();
        bus.a = 6'd7; bus.b = 6'd7; bus.func = FUNC_ADD; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_check(3, "mul ignore start");
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("no queued op", 32'(bus.done), 32'd0);
        end

        // Second request issued in the FIN cycle of the first.
        run_op(-7, 9, FUNC_MUL, "mul b2b first");
        run_op(13, -4, FUNC_MUL, "mul b2b second");

        for (int a = -32; a < 32; a++) begin
            for (int b = -32; b < 32; b++) begin
                for (int f = 0; f < 4; f++) begin
                    if (f < 2 || sel_b(b))
                        run_op(a, b, 2'(f), $sformatf("sweep a=%0d b=%0d f=%0d", a, b, f));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
